// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: sequencing opcodes, flag indices,
// FSM state codes and ROM word field offsets.
package micro_sequencer_pkg;

   localparam int unsigned AddrWDef  = 6;
   localparam int unsigned CwWDef    = 9;
   localparam int unsigned StackDDef = 2;
   localparam int unsigned SeqOpW    = 3;
   localparam int unsigned CondW     = 2;
   localparam int unsigned NumFlags  = 4;

   localparam int unsigned FlgZero  = 0;
   localparam int unsigned FlgCarry = 1;
   localparam int unsigned FlgNeg   = 2;
   localparam int unsigned FlgExt   = 3;

   typedef enum logic [2:0] {
      SeqNext = 3'd0,
      SeqJump = 3'd1,
      SeqJc   = 3'd2,
      SeqJnc  = 3'd3,
      SeqCall = 3'd4,
      SeqRet  = 3'd5,
      SeqWait = 3'd6,
      SeqEnd  = 3'd7
   } seq_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StWaitc,
      StDone
   } state_e;

   // Word layout MSB..LSB: seq_op | cond_sel | target | ctrl
   function automatic int unsigned uword_w(int unsigned addr_w, int unsigned cw_w);
      return cw_w + CondW + SeqOpW + addr_w;
   endfunction

   function automatic int unsigned target_lsb(int unsigned cw_w);
      return cw_w;
   endfunction

   function automatic int unsigned cond_lsb(int unsigned addr_w, int unsigned cw_w);
      return cw_w + addr_w;
   endfunction

   function automatic int unsigned op_lsb(int unsigned addr_w, int unsigned cw_w);
      return cw_w + addr_w + CondW;
   endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Host/ROM/decoder-facing signal bundle of the sequencer; slave is the sequencer side.
interface micro_sequencer_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned CW_W   = 9
);
   localparam int unsigned UW = CW_W + 5 + ADDR_W;

   logic              start;
   logic [ADDR_W-1:0] entry;
   logic [3:0]        flags;
   logic [ADDR_W-1:0] rom_addr;
   logic [UW-1:0]     rom_data;
   logic [CW_W-1:0]   ms_m;
   logic              ms_valid;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, entry, flags, rom_data,
      input  rom_addr, ms_m, ms_valid, busy, done, err
   );

   modport slave (
      input  start, entry, flags, rom_data,
      output rom_addr, ms_m, ms_valid, busy, done, err
   );

endinterface

// File: rtl/micro_sequencer_stack.sv
// Return-address LIFO for CALL/RET. Overflow/underflow are policed by the caller via full/empty.
module micro_sequencer_stack #(
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned STACK_D = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int unsigned SpW = $clog2(STACK_D + 1);

   logic [SpW-1:0]    sp_q, sp_d;
   logic [ADDR_W-1:0] mem_q [STACK_D];
   logic [ADDR_W-1:0] mem_d [STACK_D];

   assign empty = (sp_q == '0);
   assign full  = (sp_q == SpW'(STACK_D));

   always_comb begin
      sp_d  = sp_q;
      mem_d = mem_q;
      dout  = '0;
      for (int unsigned i = 0; i < STACK_D; i++) begin
         if (sp_q == SpW'(i + 1)) dout = mem_q[i];
         if (push && !full && (sp_q == SpW'(i))) mem_d[i] = din;
      end
      if (clr) begin
         sp_d = '0;
      end else if (push && !full) begin
         sp_d = sp_q + SpW'(1);
      end else if (pop && !empty) begin
         sp_d = sp_q - SpW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q <= '0;
         for (int unsigned i = 0; i < STACK_D; i++) mem_q[i] <= '0;
      end else begin
         sp_q  <= sp_d;
         mem_q <= mem_d;
      end
   end

   a_no_push_pop: assert property (@(posedge clk) disable iff (rst) !(push && pop));

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetches microwords from a synchronous ROM, resolves the next address
// and issues the registered control field with a start/busy/done host handshake.
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W  = AddrWDef,
   parameter int unsigned CW_W    = CwWDef,
   parameter int unsigned STACK_D = StackDDef
) (
   input logic              clk,
   input logic              rst,
   micro_sequencer_if.slave bus
);

   localparam int unsigned OpLsb   = op_lsb(ADDR_W, CW_W);
   localparam int unsigned CondLsb = cond_lsb(ADDR_W, CW_W);
   localparam int unsigned TgtLsb  = target_lsb(CW_W);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] upc_q, upc_d;
   logic [CondW-1:0]  cond_q, cond_d;
   logic [CW_W-1:0]   ms_m_q, ms_m_d;
   logic              ms_valid_q, ms_valid_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   seq_op_e           op;
   logic [CondW-1:0]  cond;
   logic [ADDR_W-1:0] tgt;
   logic [CW_W-1:0]   ctrl;
   logic [ADDR_W-1:0] upc_inc;
   logic              hit;

   logic              stk_push, stk_pop, stk_clr, stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_dout;

   assign op      = seq_op_e'(bus.rom_data[OpLsb +: SeqOpW]);
   assign cond    = bus.rom_data[CondLsb +: CondW];
   assign tgt     = bus.rom_data[TgtLsb +: ADDR_W];
   assign ctrl    = bus.rom_data[CW_W-1:0];
   assign upc_inc = upc_q + ADDR_W'(1);
   assign hit     = bus.flags[cond];

   micro_sequencer_stack #(
      .ADDR_W  (ADDR_W),
      .STACK_D (STACK_D)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .clr   (stk_clr),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (upc_inc),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty)
   );

   always_comb begin
      state_d    = state_q;
      upc_d      = upc_q;
      cond_d     = cond_q;
      ms_m_d     = ms_m_q;
      ms_valid_d = 1'b0;
      done_d     = (state_q == StDone);
      err_d      = err_q;
      stk_push   = 1'b0;
      stk_pop    = 1'b0;
      stk_clr    = 1'b0;

      case (state_q)
         StIdle: begin
            // A fresh routine starts with an empty return stack.
            if (bus.start) begin
               upc_d   = bus.entry;
               err_d   = 1'b0;
               stk_clr = 1'b1;
               state_d = StFetch;
            end
         end
         StFetch: state_d = StExec;
         StExec: begin
            ms_m_d     = ctrl;
            ms_valid_d = 1'b1;
            cond_d     = cond;
            state_d    = StFetch;
            unique case (op)
               SeqNext: upc_d = upc_inc;
               SeqJump: upc_d = tgt;
               SeqJc:   upc_d = hit ? tgt : upc_inc;
               SeqJnc:  upc_d = hit ? upc_inc : tgt;
               SeqCall: begin
                  if (stk_full) begin
                     err_d   = 1'b1;
                     state_d = StIdle;
                  end else begin
                     stk_push = 1'b1;
                     upc_d    = tgt;
                  end
               end
               SeqRet: begin
                  if (stk_empty) begin
                     err_d   = 1'b1;
                     state_d = StIdle;
                  end else begin
                     stk_pop = 1'b1;
                     upc_d   = stk_dout;
                  end
               end
               SeqWait: begin
                  if (hit) upc_d = upc_inc;
                  else     state_d = StWaitc;
               end
               SeqEnd:  state_d = StDone;
            endcase
         end
         StWaitc: begin
            if (bus.flags[cond_q]) begin
               upc_d   = upc_inc;
               state_d = StFetch;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         upc_q      <= '0;
         cond_q     <= '0;
         ms_m_q     <= '0;
         ms_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         upc_q      <= upc_d;
         cond_q     <= cond_d;
         ms_m_q     <= ms_m_d;
         ms_valid_q <= ms_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // done is registered like ms_valid, so it lands the cycle after DONE.
   assign bus.rom_addr = upc_q;
   assign bus.ms_m     = ms_m_q;
   assign bus.ms_valid = ms_valid_q;
   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = done_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a cycle-level reference model and literal checks.
module tb_micro_sequencer;

   localparam logic [2:0] OpNext = 3'd0;
   localparam logic [2:0] OpJump = 3'd1;
   localparam logic [2:0] OpJc   = 3'd2;
   localparam logic [2:0] OpJnc  = 3'd3;
   localparam logic [2:0] OpCall = 3'd4;
   localparam logic [2:0] OpRet  = 3'd5;
   localparam logic [2:0] OpWait = 3'd6;
   localparam logic [2:0] OpEnd  = 3'd7;

   localparam int PhIdle  = 0;
   localparam int PhFetch = 1;
   localparam int PhExec  = 2;
   localparam int PhWait  = 3;
   localparam int PhDone  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   micro_sequencer_if #(.ADDR_W(6), .CW_W(9)) bus ();

   micro_sequencer #(.ADDR_W(6), .CW_W(9), .STACK_D(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [19:0] rom [64];
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t0    = 0;
   logic chk_en = 1'b0;

   int m_ph = PhIdle;
   logic [5:0] m_upc;
   logic [5:0] m_stk[$];
   logic [8:0] m_mm;
   logic       m_mv, m_dn, m_er;
   logic [1:0] m_cs;

   int mv_t[$];
   int mv_v[$];
   int dn_t[$];
   int addr_at [64];

   function automatic logic [19:0] uw(input logic [2:0] op, input logic [1:0] cs,
                                      input logic [5:0] tgt, input logic [8:0] ctl);
      return {op, cs, tgt, ctl};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic [19:0] w;
      logic [2:0]  op;
      logic [1:0]  cs;
      logic [5:0]  tgt, inc;
      logic        hit;
      cyc++;
      if (rst) begin
         m_ph = PhIdle; m_upc = '0; m_stk.delete();
         m_mm = '0; m_mv = 1'b0; m_dn = 1'b0; m_er = 1'b0; m_cs = '0;
         return;
      end
      m_dn = (m_ph == PhDone);
      m_mv = 1'b0;
      inc  = m_upc + 6'd1;
      case (m_ph)
         PhIdle: if (bus.start) begin
            m_upc = bus.entry; m_er = 1'b0; m_stk.delete(); m_ph = PhFetch;
         end
         PhFetch: m_ph = PhExec;
         PhExec: begin
            w = rom[m_upc];
            {op, cs, tgt, m_mm} = w;
            m_mv = 1'b1; m_cs = cs; hit = bus.flags[cs]; m_ph = PhFetch;
            case (op)
               OpNext: m_upc = inc;
               OpJump: m_upc = tgt;
               OpJc:   m_upc = hit ? tgt : inc;
               OpJnc:  m_upc = hit ? inc : tgt;
               OpCall: if (m_stk.size() == 2) begin m_er = 1'b1; m_ph = PhIdle; end
                       else begin m_stk.push_back(inc); m_upc = tgt; end
               OpRet:  if (m_stk.size() == 0) begin m_er = 1'b1; m_ph = PhIdle; end
                       else m_upc = m_stk.pop_back();
               OpWait: if (hit) m_upc = inc; else m_ph = PhWait;
               default: m_ph = PhDone;
            endcase
         end
         PhWait: if (bus.flags[m_cs]) begin m_upc = inc; m_ph = PhFetch; end
         default: m_ph = PhIdle;
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      int rel;
      @(negedge clk);
      if (chk_en) begin
         check("rom_addr", int'(bus.rom_addr), int'(m_upc));
         check("ms_m",     int'(bus.ms_m),     int'(m_mm));
         check("ms_valid", int'(bus.ms_valid), int'(m_mv));
         check("busy",     int'(bus.busy),     int'(m_ph != PhIdle));
         check("done",     int'(bus.done),     int'(m_dn));
         check("err",      int'(bus.err),      int'(m_er));
         rel = cyc - t0;
         if (bus.ms_valid) begin mv_t.push_back(rel); mv_v.push_back(int'(bus.ms_m)); end
         if (bus.done) dn_t.push_back(rel);
         if (rel >= 0 && rel < 64) addr_at[rel] = int'(bus.rom_addr);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic tick_to(input int r);
      while (cyc - t0 < r) tick();
   endtask

   task automatic rom_clear();
      foreach (rom[i]) rom[i] = '0;
   endtask

   task automatic run(input logic [5:0] e);
      t0 = cyc;
      mv_t.delete(); mv_v.delete(); dn_t.delete();
      foreach (addr_at[i]) addr_at[i] = -1;
      bus.entry = e;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   logic [2:0] t2_op [4] = '{OpJc, OpJc, OpJnc, OpJnc};
   logic [3:0] t2_fl [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
   int         t2_ex [4] = '{5, 1, 1, 5};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0; bus.entry = '0; bus.flags = '0;
      rom_clear();
      repeat (3) tick();
      check("rst_busy",     int'(bus.busy),     0);
      check("rst_rom_addr", int'(bus.rom_addr), 0);
      check("rst_ms_m",     int'(bus.ms_m),     0);
      check("rst_ms_valid", int'(bus.ms_valid), 0);
      check("rst_done",     int'(bus.done),     0);
      check("rst_err",      int'(bus.err),      0);
      rst = 1'b0;
      chk_en = 1'b1;
      tick();

      // Straight line
      rom_clear();
      rom[0] = uw(OpNext, 2'd0, 6'd0, 9'b000_010_010);
      rom[1] = uw(OpNext, 2'd0, 6'd0, 9'b001_110_001);
      rom[2] = uw(OpEnd,  2'd0, 6'd0, 9'b111_100_100);
      run(6'd0);
      tick_to(9);
      check("t1_mv_count", mv_t.size(), 3);
      if (mv_t.size() == 3) begin
         check("t1_mv_t0", mv_t[0], 3); check("t1_mv_v0", mv_v[0], 'h012);
         check("t1_mv_t1", mv_t[1], 5); check("t1_mv_v1", mv_v[1], 'h071);
         check("t1_mv_t2", mv_t[2], 7); check("t1_mv_v2", mv_v[2], 'h1E4);
      end
      check("t1_done_count", dn_t.size(), 1);
      if (dn_t.size() == 1) check("t1_done_t", dn_t[0], 8);
      check("t1_busy_t9", int'(bus.busy), 0);
      tick_to(11);

      // Conditional branch
      for (int i = 0; i < 4; i++) begin
         rom_clear();
         rom[0] = uw(t2_op[i], 2'd0, 6'd5, 9'h0AA);
         rom[1] = uw(OpEnd, 2'd0, 6'd0, 9'h001);
         rom[5] = uw(OpEnd, 2'd0, 6'd0, 9'h005);
         bus.flags = t2_fl[i];
         run(6'd0);
         tick_to(3);
         check("t2_branch_addr", addr_at[3], t2_ex[i]);
         tick_to(8);
      end
      bus.flags = '0;

      // Call/return
      rom_clear();
      rom[0]  = uw(OpCall, 2'd0, 6'd10, 9'h0C0);
      rom[10] = uw(OpRet,  2'd0, 6'd0,  9'h0D0);
      rom[1]  = uw(OpEnd,  2'd0, 6'd0,  9'h0E0);
      run(6'd0);
      tick_to(9);
      check("t3_addr_1", addr_at[1], 0);
      check("t3_addr_3", addr_at[3], 10);
      check("t3_addr_5", addr_at[5], 1);
      check("t3_done_count", dn_t.size(), 1);
      if (dn_t.size() == 1) check("t3_done_t", dn_t[0], 8);
      check("t3_err", int'(bus.err), 0);
      check("t3_stack_empty", int'(dut.u_stack.empty), 1);
      tick_to(11);

      // Stack overflow, then clear on restart, then underflow
      rom_clear();
      rom[0] = uw(OpCall, 2'd0, 6'd1, 9'h011);
      rom[1] = uw(OpCall, 2'd0, 6'd2, 9'h022);
      rom[2] = uw(OpCall, 2'd0, 6'd3, 9'h033);
      rom[3] = uw(OpEnd,  2'd0, 6'd0, 9'h044);
      run(6'd0);
      tick_to(10);
      check("t4_err", int'(bus.err), 1);
      check("t4_busy", int'(bus.busy), 0);
      check("t4_done_count", dn_t.size(), 0);
      check("t4_mv_count", mv_t.size(), 3);
      rom_clear();
      rom[0] = uw(OpRet, 2'd0, 6'd0, 9'h055);
      run(6'd0);
      check("t4_err_cleared", int'(bus.err), 0);
      tick_to(4);
      check("t4_ret_err", int'(bus.err), 1);
      check("t4_ret_busy", int'(bus.busy), 0);
      check("t4_ret_done_count", dn_t.size(), 0);
      tick_to(6);

      // Wait on ext_ready
      rom_clear();
      rom[0] = uw(OpWait, 2'd3, 6'd0, 9'h0F0);
      rom[1] = uw(OpEnd,  2'd0, 6'd0, 9'h00F);
      bus.flags = 4'b0000;
      run(6'd0);
      tick_to(6);
      bus.flags = 4'b1000;
      tick_to(8);
      check("t5_busy_waitc", int'(bus.busy), 1);
      check("t5_addr_waitc", addr_at[6], 0);
      check("t5_addr_after", addr_at[7], 1);
      check("t5_mv_count", mv_t.size(), 1);
      if (mv_t.size() == 1) check("t5_mv_t", mv_t[0], 3);
      tick_to(12);
      bus.flags = '0;

      // Reset mid-routine with start held
      rom_clear();
      foreach (rom[i]) rom[i] = uw(OpNext, 2'd0, 6'd0, 9'h155);
      run(6'd0);
      tick_to(5);
      rst = 1'b1;
      bus.start = 1'b1;
      tick();
      check("t6_rst_rom_addr", int'(bus.rom_addr), 0);
      check("t6_rst_ms_m",     int'(bus.ms_m),     0);
      check("t6_rst_ms_valid", int'(bus.ms_valid), 0);
      check("t6_rst_busy",     int'(bus.busy),     0);
      check("t6_rst_done",     int'(bus.done),     0);
      rst = 1'b0;
      bus.start = 1'b0;
      tick();

      // Address wrap 63 -> 0
      rom_clear();
      rom[63] = uw(OpNext, 2'd0, 6'd0, 9'h033);
      rom[0]  = uw(OpEnd,  2'd0, 6'd0, 9'h066);
      run(6'd63);
      tick_to(7);
      check("t6_wrap_addr", addr_at[3], 0);
      check("t6_wrap_done_count", dn_t.size(), 1);
      if (dn_t.size() == 1) check("t6_wrap_done_t", dn_t[0], 6);

      // Start during DONE is ignored
      rom_clear();
      rom[0] = uw(OpEnd, 2'd0, 6'd0, 9'h077);
      run(6'd0);
      tick_to(3);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("t6_done_start_busy4", int'(bus.busy), 0);
      check("t6_done_count", dn_t.size(), 1);
      if (dn_t.size() == 1) check("t6_done_t", dn_t[0], 4);
      tick();
      check("t6_done_start_busy5", int'(bus.busy), 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
